// File: rtl/mux_arb_4_1.sv
// mux_arb_4_1: four valid/ready requesters sharing one WIDTH-bit 4:1 mux into a one-entry output register
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   d0..d3     requester data, WIDTH bits each
//   in_valid   bit i set: di holds valid data
//   in_ready   one-hot grant; bit i set: di is consumed this cycle (combinational)
//   y          registered output data
//   sel        index of the requester whose data is in y
//   out_valid  y and sel are valid
//   out_ready  downstream accepts y this cycle
//
// Configuration:
//   MUX_ARB_4_1_RR_EN defined   -> round-robin arbitration starting after the last grant
//   MUX_ARB_4_1_RR_EN undefined -> fixed priority, lowest set in_valid index wins
module mux_arb_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic             slot_free;
  logic             fire;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  // Slot frees when empty or being drained, so drain and refill share a cycle.
  assign slot_free = !out_valid_q || out_ready;
  // Gating with rst keeps in_ready low while reset is held.
  assign fire = slot_free && (|in_valid) && !rst;
  // First set request searching ptr, ptr+1, ptr+2, ptr+3; 2-bit add wraps mod 4.
  always_comb begin
    grant = 2'd0;
    found = 1'b0;
    idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  assign in_ready = fire ? 4'(4'b0001 << grant) : 4'b0000;
  always_comb begin
    y_d = fire ? (grant == 2'd0 ? d0 : grant == 2'd1 ? d1 : grant == 2'd2 ? d2 : d3) : y_q;
    sel_d = fire ? grant : sel_q;
    out_valid_d = fire ? 1'b1 : (slot_free ? 1'b0 : out_valid_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
      sel_q <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      y_q <= y_d;
      sel_q <= sel_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef MUX_ARB_4_1_RR_EN
  logic [1:0] ptr_q, ptr_d;
  // Only a grant moves the pointer; dropped requests leave it alone.
  assign ptr_d = fire ? grant + 2'd1 : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 2'd0;
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = 2'd0;
`endif
  assign y = y_q;
  assign sel = sel_q;
  assign out_valid = out_valid_q;
endmodule
